// File: rtl/wb_daq_sample_packer.sv
// Packs ADC samples (optionally decimated) into dw-bit words of 4, 2 or 1 lanes.
// Latency: the kept sample that completes a word appears on word_valid/word_data the next cycle.
// Backpressure: word_valid/word_ready handshake. A completing sample that arrives while the
// output register is full is dropped and sets overflow.
// Ports: wb_clk/wb_rst (async active-high); enable, sample_valid/sample_data, data_width,
//        decimator_select, flush, clear_overflow, word_ready in; word_valid, word_data,
//        overflow, word_count out.
module wb_daq_sample_packer #(
   parameter int dw     = 32,
   parameter int adc_dw = 8
) (
   input  logic              wb_clk,
   input  logic              wb_rst,
   input  logic              enable,
   input  logic              sample_valid,
   input  logic [adc_dw-1:0] sample_data,
   input  logic [2:0]        data_width,
   input  logic [1:0]        decimator_select,
   input  logic              flush,
   input  logic              clear_overflow,
   input  logic              word_ready,
   output logic              word_valid,
   output logic [dw-1:0]     word_data,
   output logic              overflow,
   output logic [15:0]       word_count
);

   logic          enable_q, enable_d;
   logic [2:0]    mode_q, mode_d;
   logic [1:0]    dec_sel_q, dec_sel_d;
   logic [2:0]    dec_cnt_q, dec_cnt_d;
   logic [1:0]    lane_q, lane_d;
   logic [dw-1:0] part_q, part_d;
   logic          pend_q, pend_d;
   logic          vld_q, vld_d;
   logic [dw-1:0] dat_q, dat_d;
   logic          ovf_q, ovf_d;
   logic [15:0]   cnt_q, cnt_d;

   logic          rise;
   logic [2:0]    mode_eff;
   logic [1:0]    dec_eff;
   logic [2:0]    spw;
   logic [1:0]    lane_last;
   int            lane_w;
   logic [2:0]    dec_mask;
   logic          keep;
   logic          free;
   logic [dw-1:0] sample_ext;
   logic [dw-1:0] merged;
   logic [1:0]    lane_m;
   logic [dw-1:0] part_m;
   logic          complete;
   logic          ovf_set;

   always_comb begin
      // The mode registers load on the enable rising edge; that same cycle already
      // uses the incoming values so a sample arriving with enable is packed correctly.
      rise     = enable & ~enable_q;
      mode_eff = rise ? data_width : mode_q;
      dec_eff  = rise ? decimator_select : dec_sel_q;

      spw    = 3'd4;
      lane_w = dw / 4;
      case (mode_eff)
         3'd1: begin spw = 3'd2; lane_w = dw / 2; end
         3'd2: begin spw = 3'd1; lane_w = dw;     end
         default: ;
      endcase
      lane_last = spw[1:0] - 2'd1;

      dec_mask = 3'd0;
      case (dec_eff)
         2'd1: dec_mask = 3'd1;
         2'd2: dec_mask = 3'd3;
         2'd3: dec_mask = 3'd7;
         default: ;
      endcase

      keep       = enable & sample_valid & ((dec_cnt_q & dec_mask) == 3'd0);
      free       = ~vld_q | word_ready;
      sample_ext = dw'(sample_data);
      merged     = part_q | (sample_ext << (int'(lane_q) * lane_w));

      enable_d  = enable;
      mode_d    = mode_eff;
      dec_sel_d = dec_eff;
      dec_cnt_d = dec_cnt_q;
      lane_d    = lane_q;
      part_d    = part_q;
      pend_d    = pend_q;
      vld_d     = vld_q & ~word_ready;
      dat_d     = dat_q;
      ovf_set   = 1'b0;
      lane_m    = lane_q;
      part_m    = part_q;
      complete  = 1'b0;

      cnt_d = cnt_q + {15'd0, vld_q & word_ready};
      if (rise) cnt_d = 16'd0;

      if (!enable) begin
         dec_cnt_d = 3'd0;
         lane_d    = 2'd0;
         part_d    = '0;
         pend_d    = 1'b0;
      end else begin
         if (sample_valid) dec_cnt_d = (dec_cnt_q + 3'd1) & dec_mask;

         // Merge the kept sample first so a simultaneous flush sees it.
         if (keep) begin
            if (lane_q == lane_last) complete = 1'b1;
            else begin
               lane_m = lane_q + 2'd1;
               part_m = merged;
            end
         end

         if (complete) begin
            if (free) begin
               vld_d  = 1'b1;
               dat_d  = merged;
               lane_d = 2'd0;
               part_d = '0;
               pend_d = 1'b0;
            end else begin
               // Drop the completing sample; the partial word is left intact.
               ovf_set = 1'b1;
            end
         end else if ((pend_q | flush) && lane_m != 2'd0) begin
            if (free) begin
               vld_d  = 1'b1;
               dat_d  = part_m;
               lane_d = 2'd0;
               part_d = '0;
               pend_d = 1'b0;
            end else begin
               pend_d = 1'b1;
               lane_d = lane_m;
               part_d = part_m;
            end
         end else begin
            lane_d = lane_m;
            part_d = part_m;
            pend_d = 1'b0;
         end
      end

      ovf_d = ovf_set | (ovf_q & ~clear_overflow);
   end

   always_ff @(posedge wb_clk or posedge wb_rst) begin
      if (wb_rst) begin
         enable_q  <= 1'b0;
         mode_q    <= 3'd0;
         dec_sel_q <= 2'd0;
         dec_cnt_q <= 3'd0;
         lane_q    <= 2'd0;
         part_q    <= '0;
         pend_q    <= 1'b0;
         vld_q     <= 1'b0;
         dat_q     <= '0;
         ovf_q     <= 1'b0;
         cnt_q     <= 16'd0;
      end else begin
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         dec_sel_q <= dec_sel_d;
         dec_cnt_q <= dec_cnt_d;
         lane_q    <= lane_d;
         part_q    <= part_d;
         pend_q    <= pend_d;
         vld_q     <= vld_d;
         dat_q     <= dat_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
      end
   end

   assign word_valid = vld_q;
   assign word_data  = dat_q;
   assign overflow   = ovf_q;
   assign word_count = cnt_q;

endmodule

// File: tb/tb_wb_daq_sample_packer.sv
// Testbench for wb_daq_sample_packer: directed scenarios plus a randomized run checked
// against a queue-based reference model of the packing, decimation and handshake rules.
module tb_wb_daq_sample_packer;

   logic        wb_clk = 1'b0;
   logic        wb_rst = 1'b1;
   logic        enable = 1'b0;
   logic        sample_valid = 1'b0;
   logic [7:0]  sample_data = 8'd0;
   logic [2:0]  data_width = 3'd0;
   logic [1:0]  decimator_select = 2'd0;
   logic        flush = 1'b0;
   logic        clear_overflow = 1'b0;
   logic        word_ready = 1'b1;
   logic        word_valid;
   logic [31:0] word_data;
   logic        overflow;
   logic [15:0] word_count;

   int checks = 0;
   int errors = 0;

   wb_daq_sample_packer #(.dw(32), .adc_dw(8)) dut (
      .wb_clk(wb_clk), .wb_rst(wb_rst), .enable(enable),
      .sample_valid(sample_valid), .sample_data(sample_data),
      .data_width(data_width), .decimator_select(decimator_select),
      .flush(flush), .clear_overflow(clear_overflow), .word_ready(word_ready),
      .word_valid(word_valid), .word_data(word_data),
      .overflow(overflow), .word_count(word_count)
   );

   always #5 wb_clk = ~wb_clk;

   // Reference model: kept samples of the current word live in a queue.
   bit          m_en_prev;
   int          m_mode, m_dec, m_seen, m_cnt;
   logic [7:0]  m_q[$];
   bit          m_pend, m_vld, m_ovf;
   logic [31:0] m_dat;

   function automatic logic [31:0] pack_word(input int spw);
      logic [31:0] w = 32'd0;
      int lw = 32 / spw;
      foreach (m_q[i]) w = w | (32'(m_q[i]) << (i * lw));
      return w;
   endfunction

   task automatic model_reset();
      m_en_prev = 0; m_mode = 0; m_dec = 0; m_seen = 0; m_cnt = 0;
      m_q.delete(); m_pend = 0; m_vld = 0; m_ovf = 0; m_dat = 32'd0;
   endtask

   task automatic model_update();
      bit rise = enable && !m_en_prev;
      bit free, done, set;
      int spw, n;
      if (rise) begin m_mode = int'(data_width); m_dec = int'(decimator_select); end
      spw = (m_mode == 1) ? 2 : (m_mode == 2) ? 1 : 4;
      n = 1 << m_dec;
      free = !m_vld || word_ready;
      set = 0;
      if (m_vld && word_ready) begin m_vld = 0; m_cnt = (m_cnt + 1) % 65536; end
      if (rise) m_cnt = 0;
      if (!enable) begin
         m_q.delete(); m_seen = 0; m_pend = 0;
      end else begin
         done = 0;
         if (sample_valid) begin
            if (m_seen % n == 0) begin
               if (m_q.size() + 1 == spw) begin
                  done = 1;
                  if (free) begin
                     m_q.push_back(sample_data);
                     m_dat = pack_word(spw); m_vld = 1; m_q.delete(); m_pend = 0;
                  end else set = 1;
               end else m_q.push_back(sample_data);
            end
            m_seen++;
         end
         if (!done) begin
            if ((m_pend || flush) && m_q.size() > 0) begin
               if (free) begin
                  m_dat = pack_word(spw); m_vld = 1; m_q.delete(); m_pend = 0;
               end else m_pend = 1;
            end else m_pend = 0;
         end
      end
      if (set) m_ovf = 1;
      else if (clear_overflow) m_ovf = 0;
      m_en_prev = enable;
   endtask

   // Advance one clock; inputs are sampled by model and DUT at the same edge.
   task automatic step();
      model_update();
      @(posedge wb_clk);
      #1;
   endtask

   task automatic idle();
      sample_valid = 0; flush = 0; clear_overflow = 0;
   endtask

   task automatic restart(input logic [2:0] dwm, input logic [1:0] dec);
      idle(); enable = 0; step();
      data_width = dwm; decimator_select = dec; enable = 1; step();
   endtask

   task automatic test_reset();
      model_reset();
      wb_rst = 1; #1;
      checks++;
      if (word_valid !== 1'b0 || word_data !== 32'd0 || overflow !== 1'b0 || word_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: vld=%b dat=%h ovf=%b cnt=%0d required all zero",
                  word_valid, word_data, overflow, word_count);
      end
      @(negedge wb_clk); @(negedge wb_clk);
      wb_rst = 0;
      @(posedge wb_clk); #1;
   endtask

   task automatic test_pack8();
      logic [7:0] s[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      word_ready = 1;
      restart(3'd0, 2'd0);
      for (int i = 0; i < 4; i++) begin
         sample_valid = 1; sample_data = s[i]; step();
         if (i < 3) begin
            checks++;
            if (word_valid !== 1'b0) begin
               errors++; $display("FAIL pack8_early: vld=%b after %0d samples required 0", word_valid, i + 1);
            end
         end
      end
      idle();
      checks++;
      if (word_valid !== 1'b1 || word_data !== 32'h44332211) begin
         errors++; $display("FAIL pack8_word: vld=%b dat=%h required 1 44332211", word_valid, word_data);
      end
      step();
      checks++;
      if (word_count !== 16'd1 || word_valid !== 1'b0) begin
         errors++; $display("FAIL pack8_count: cnt=%0d vld=%b required 1 0", word_count, word_valid);
      end
   endtask

   task automatic test_decim();
      int nwords = 0;
      logic [31:0] got = 32'd0;
      word_ready = 1;
      restart(3'd1, 2'd2);
      for (int i = 1; i <= 8; i++) begin
         sample_valid = 1; sample_data = 8'(i); step();
         if (word_valid) begin nwords++; got = word_data; end
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         step();
         if (word_valid) begin nwords++; got = word_data; end
      end
      checks++;
      if (nwords != 1 || got !== 32'h00050001) begin
         errors++; $display("FAIL decim_word: words=%0d dat=%h required 1 00050001", nwords, got);
      end
   endtask

   task automatic test_backpressure();
      word_ready = 0;
      restart(3'd2, 2'd0);
      sample_valid = 1; sample_data = 8'hAA; step();
      checks++;
      if (word_valid !== 1'b1 || word_data !== 32'h000000AA) begin
         errors++; $display("FAIL bp_first: vld=%b dat=%h required 1 000000AA", word_valid, word_data);
      end
      sample_data = 8'hBB; step();
      idle();
      checks++;
      if (word_data !== 32'h000000AA || overflow !== 1'b1) begin
         errors++; $display("FAIL bp_drop: dat=%h ovf=%b required 000000AA 1", word_data, overflow);
      end
      clear_overflow = 1; step(); idle();
      checks++;
      if (overflow !== 1'b0 || word_valid !== 1'b1 || word_data !== 32'h000000AA) begin
         errors++; $display("FAIL bp_clear: ovf=%b vld=%b dat=%h required 0 1 000000AA", overflow, word_valid, word_data);
      end
      word_ready = 1; step();
      checks++;
      if (word_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain: vld=%b required 0", word_valid);
      end
   endtask

   task automatic test_flush();
      word_ready = 1;
      restart(3'd0, 2'd0);
      sample_valid = 1; sample_data = 8'h10; step();
      sample_data = 8'h20; step();
      idle(); flush = 1; step(); idle();
      checks++;
      if (word_valid !== 1'b1 || word_data !== 32'h00002010) begin
         errors++; $display("FAIL flush_partial: vld=%b dat=%h required 1 00002010", word_valid, word_data);
      end
      step();
      flush = 1; step(); idle();
      checks++;
      if (word_valid !== 1'b0) begin
         errors++; $display("FAIL flush_empty: vld=%b required 0", word_valid);
      end
   endtask

   task automatic test_shadow();
      word_ready = 1;
      restart(3'd0, 2'd0);
      data_width = 3'd2;
      for (int i = 1; i <= 4; i++) begin
         sample_valid = 1; sample_data = 8'(i); step();
         if (i < 4) begin
            checks++;
            if (word_valid !== 1'b0) begin
               errors++; $display("FAIL shadow_early: vld=%b after sample %0d required 0", word_valid, i);
            end
         end
      end
      idle();
      checks++;
      if (word_valid !== 1'b1 || word_data !== 32'h04030201) begin
         errors++; $display("FAIL shadow_word: vld=%b dat=%h required 1 04030201", word_valid, word_data);
      end
      enable = 0; step();
      enable = 1; step();
      checks++;
      if (word_count !== 16'd0) begin
         errors++; $display("FAIL shadow_count: cnt=%0d required 0", word_count);
      end
      sample_valid = 1; sample_data = 8'h55; step(); idle();
      checks++;
      if (word_valid !== 1'b1 || word_data !== 32'h00000055) begin
         errors++; $display("FAIL shadow_new: vld=%b dat=%h required 1 00000055", word_valid, word_data);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int nwords = 0;
      word_ready = 1;
      restart(3'd0, 2'd0);
      for (int i = 0; i < 3; i++) begin
         sample_valid = 1; sample_data = 8'(8'hA0 + i); step();
      end
      idle();
      @(negedge wb_clk);
      wb_rst = 1; #1;
      model_reset();
      checks++;
      if (word_valid !== 1'b0 || word_data !== 32'd0 || overflow !== 1'b0 || word_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_mid: vld=%b dat=%h ovf=%b cnt=%0d required all zero",
                  word_valid, word_data, overflow, word_count);
      end
      @(negedge wb_clk); wb_rst = 0;
      @(posedge wb_clk); #1;
      sample_valid = 1; sample_data = 8'hA3; step(); idle();
      if (word_valid) nwords++;
      for (int i = 0; i < 3; i++) begin step(); if (word_valid) nwords++; end
      checks++;
      if (nwords != 0) begin
         errors++; $display("FAIL reset_discard: words=%0d required 0", nwords);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 2) enable = ~enable;
         else if (!enable && $urandom_range(0, 3) == 0) enable = 1;
         data_width       = 3'($urandom_range(0, 7));
         decimator_select = 2'($urandom_range(0, 3));
         sample_valid     = ($urandom_range(0, 99) < 60);
         sample_data      = 8'($urandom);
         flush            = ($urandom_range(0, 99) < 10);
         clear_overflow   = ($urandom_range(0, 99) < 5);
         word_ready       = ($urandom_range(0, 99) < 55);
         step();
         checks++;
         if (word_valid !== m_vld) begin
            errors++; $display("FAIL rand_vld cyc %0d: got %b required %b", c, word_valid, m_vld);
         end
         if (m_vld) begin
            checks++;
            if (word_data !== m_dat) begin
               errors++; $display("FAIL rand_dat cyc %0d: got %h required %h", c, word_data, m_dat);
            end
         end
         checks++;
         if (overflow !== m_ovf) begin
            errors++; $display("FAIL rand_ovf cyc %0d: got %b required %b", c, overflow, m_ovf);
         end
         checks++;
         if (word_count !== 16'(m_cnt)) begin
            errors++; $display("FAIL rand_cnt cyc %0d: got %0d required %0d", c, word_count, m_cnt);
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_pack8();
      test_decim();
      test_backpressure();
      test_flush();
      test_shadow();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_daq_sample_packer.md
WB_DAQ_SAMPLE_PACKER -- requirements
Module: wb_daq_sample_packer

Interface
REQ-001 SHALL have parameter dw, default 32, output word width.
REQ-002 SHALL have parameter adc_dw, default 8, ADC sample width.
REQ-003 SHALL have port wb_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port wb_rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port enable, input, 1, channel enable (master_enable AND channel control enable).
REQ-006 SHALL have port sample_valid, input, 1, one ADC sample present this cycle.
REQ-007 SHALL have port sample_data, input, adc_dw, ADC sample.
REQ-008 SHALL have port data_width, input, 3, packing mode (control[7:5]).
REQ-009 SHALL have port decimator_select, input, 2, decimation mode (control[9:8]).
REQ-010 SHALL have port flush, input, 1, single-cycle request to emit a partial word.
REQ-011 SHALL have port clear_overflow, input, 1, single-cycle clear of overflow.
REQ-012 SHALL have port word_ready, input, 1, downstream channel FIFO can accept.
REQ-013 SHALL have port word_valid, output, 1, word_data holds a word.
REQ-014 SHALL have port word_data, output, dw, packed word.
REQ-015 SHALL have port overflow, output, 1, sticky sample-drop flag.
REQ-016 SHALL have port word_count, output, 16, words accepted downstream since enable rose.

Function
REQ-017 SHALL capture data_width and decimator_select into shadow registers on the cycle enable goes 0->1; changes while enable=1 ignored.
REQ-018 Samples per word (SPW) SHALL be: data_width 0 -> 4 (8-bit lanes); 1 -> 2 (sample zero-extended to 16 bits); 2 -> 1 (zero-extended to 32); 3..7 -> treated as 0.
REQ-019 Decimation factor SHALL be 1,2,4,8 for decimator_select 0,1,2,3; mod-N counter advances on every sample_valid while enabled; only the sample at count 0 is kept.
REQ-020 First kept sample of a word SHALL occupy the least-significant lane; subsequent samples fill ascending lanes.
REQ-021 Handshake: word transfers when word_valid=1 and word_ready=1; word_data SHALL stay stable while word_valid=1 and word_ready=0.
REQ-022 Latency: kept sample completing a word in cycle N -> word_valid=1 with that word in cycle N+1 (no bubble when output register drains in cycle N).
REQ-023 Output register SHALL be considered free in cycle N if word_valid=0 or word_ready=1 in N.
REQ-024 Kept sample completing a word while output register not free SHALL be dropped, overflow set, partial-word lanes and lane counter unchanged.
REQ-025 Non-completing kept samples SHALL never be dropped.
REQ-026 flush with lane counter 0 SHALL be a no-op; otherwise a flush_pending flag SHALL be set and the partial word emitted, unused lanes zero, on the first cycle the output register is free, lane counter then 0.
REQ-027 Kept sample and flush in same cycle: sample SHALL be merged first; if it completes the word, normal emission and flush is a no-op; otherwise merged partial word is flushed.
REQ-028 enable=0 SHALL clear lane counter, decimation counter, partial word, flush_pending; a pending word_valid SHALL remain until accepted.
REQ-029 sample_valid, flush SHALL be ignored while enable=0.
REQ-030 word_count SHALL increment by 1 per transfer, wrap 0xFFFF->0x0000, clear on enable 0->1 (clear wins over increment).
REQ-031 overflow SHALL clear on clear_overflow; simultaneous set and clear: set wins.

Reset
REQ-032 On wb_rst=1, immediately: word_valid=0, word_data=0, overflow=0, word_count=0, all counters, shadows, flush_pending, partial word = 0.
REQ-033 Reset mid-word SHALL discard partial and pending words; no word emitted after release until new samples complete one.

Verification
REQ-034 data_width=0, dec=0, word_ready=1, samples 0x11,0x22,0x33,0x44 consecutive -> word_valid one cycle after 4th, word_data=0x44332211, word_count=1.
REQ-035 data_width=1, dec=2 (÷4), 8 samples 0x01..0x08 -> one word 0x00050001.
REQ-036 data_width=2, word_ready=0, samples 0xAA,0xBB -> word_data=0x000000AA held, 0xBB dropped, overflow=1; clear_overflow -> overflow=0.
REQ-037 data_width=0, samples 0x10,0x20 then flush -> word_data=0x00002010 next cycle; flush with no partial -> no word.
REQ-038 data_width changed to 2 while enabled -> packing remains 4/word until enable toggled 1->0->1, then 1/word, word_count=0.
REQ-039 wb_rst asserted after 3 of 4 samples -> all outputs 0 same cycle; after release 1 more sample emits nothing.
